// File: rtl/execute_pipe.sv
// execute_pipe: single-issue execute stage with a one-entry result register and valid/ready handshakes.
// Define EXECUTE_MULDIV_EN to add MUL and a multi-cycle restoring divider (DIV/DIVU/REM/REMU).
module execute_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rd,
    output logic [XLEN-1:0] out_jump_dest,
    output logic            out_jump,
    output logic            out_illegal,
    output logic            busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam int unsigned SHW = $clog2(XLEN);

    logic [1:0]      state_q, state_d;
    logic            take_in, take_out;
    logic [XLEN-1:0] link, tgt;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_rd, alu_dest;
    logic            alu_jump, alu_illegal, is_div;
    logic            div_done;
    logic [XLEN-1:0] div_res;

    assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
    assign out_valid = (state_q == HOLD);
    assign take_in   = in_valid && in_ready;
    assign take_out  = out_valid && out_ready;

    assign link  = in_pc + XLEN'(PC_STEP);
    assign tgt   = in_pc + in_imm;
    assign shamt = in_rs2[SHW-1:0];

    always_comb begin
        alu_rd      = '0;
        alu_dest    = link;
        alu_jump    = 1'b0;
        alu_illegal = 1'b0;
        is_div      = 1'b0;
        case (in_op)
            5'd0:  alu_rd = in_rs1 + in_rs2;
            5'd1:  alu_rd = in_rs1 - in_rs2;
            5'd2:  alu_rd = in_rs1 & in_rs2;
            5'd3:  alu_rd = in_rs1 | in_rs2;
            5'd4:  alu_rd = in_rs1 ^ in_rs2;
            5'd5:  alu_rd = in_rs1 << shamt;
            5'd6:  alu_rd = in_rs1 >> shamt;
            5'd7:  alu_rd = $signed(in_rs1) >>> shamt;
            5'd8:  alu_rd = {{(XLEN-1){1'b0}}, $signed(in_rs1) < $signed(in_rs2)};
            5'd9:  alu_rd = {{(XLEN-1){1'b0}}, in_rs1 < in_rs2};
            5'd10: alu_jump = (in_rs1 == in_rs2);
            5'd11: alu_jump = (in_rs1 != in_rs2);
            5'd12: alu_jump = ($signed(in_rs1) < $signed(in_rs2));
            5'd13: alu_jump = ($signed(in_rs1) >= $signed(in_rs2));
            5'd14: begin
                alu_rd   = link;
                alu_jump = 1'b1;
            end
            5'd15: begin
                alu_rd   = link;
                alu_jump = 1'b1;
            end
`ifdef EXECUTE_MULDIV_EN
            5'd16: alu_rd = in_rs1 * in_rs2;
            5'd17, 5'd18, 5'd19, 5'd20: is_div = 1'b1;
`endif
            default: alu_illegal = 1'b1;
        endcase
        // Taken branches and JAL share pc+imm; JALR forms its target from rs1
        if (alu_jump) begin
            alu_dest = (in_op == 5'd15) ? ((in_rs1 + in_imm) & ~XLEN'(1)) : tgt;
        end
    end

`ifdef EXECUTE_MULDIV_EN
    localparam int unsigned CW = $clog2(XLEN) + 1;

    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] dvd_q, dvs_q, rem_q, orig_q;
    logic            q_neg_q, r_neg_q, want_rem_q, dz_q;
    logic            signed_op, a_neg, b_neg;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] rem_nx, q_nx, quot, remv;

    assign signed_op = (in_op == 5'd17) || (in_op == 5'd19);
    assign a_neg     = signed_op && in_rs1[XLEN-1];
    assign b_neg     = signed_op && in_rs2[XLEN-1];

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_sh = {rem_q, dvd_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (diff[XLEN]) begin
            rem_nx = rem_sh[XLEN-1:0];
            q_nx   = {dvd_q[XLEN-2:0], 1'b0};
        end else begin
            rem_nx = diff[XLEN-1:0];
            q_nx   = {dvd_q[XLEN-2:0], 1'b1};
        end
        quot = q_neg_q ? -q_nx : q_nx;
        remv = r_neg_q ? -rem_nx : rem_nx;
        if (dz_q) begin
            div_res = want_rem_q ? orig_q : '1;
        end else begin
            div_res = want_rem_q ? remv : quot;
        end
    end

    assign div_done = (state_q == DIV) && (cnt_q == CW'(XLEN - 1));
    assign busy     = (state_q == DIV);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            orig_q     <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            want_rem_q <= 1'b0;
            dz_q       <= 1'b0;
        end else if (take_in && is_div) begin
            cnt_q      <= '0;
            dvd_q      <= a_neg ? -in_rs1 : in_rs1;
            dvs_q      <= b_neg ? -in_rs2 : in_rs2;
            rem_q      <= '0;
            orig_q     <= in_rs1;
            q_neg_q    <= a_neg ^ b_neg;
            r_neg_q    <= a_neg;
            want_rem_q <= (in_op == 5'd19) || (in_op == 5'd20);
            dz_q       <= (in_rs2 == '0);
        end else if (state_q == DIV) begin
            cnt_q <= (flush || div_done) ? '0 : cnt_q + CW'(1);
            dvd_q <= q_nx;
            rem_q <= rem_nx;
        end
    end
`else
    assign div_done = 1'b0;
    assign div_res  = '0;
    assign busy     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (take_in) state_d = is_div ? DIV : HOLD;
            DIV:  if (div_done) state_d = HOLD;
            HOLD: begin
                if (take_in) begin
                    state_d = is_div ? DIV : HOLD;
                end else if (take_out) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result register only loads on acceptance or divider completion, so it holds under stall
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_rd        <= '0;
            out_jump_dest <= '0;
            out_jump      <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (take_in) begin
            out_rd        <= alu_rd;
            out_jump_dest <= alu_dest;
            out_jump      <= alu_jump;
            out_illegal   <= alu_illegal;
        end else if (div_done && !flush) begin
            out_rd <= div_res;
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// Randomized bench for execute_pipe against a transaction-level reference model.
// Follows EXECUTE_MULDIV_EN so the same bench covers both builds.
module tb_execute_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  in_op = '0;
    logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
    logic        in_ready, out_valid, out_jump, out_illegal, busy;
    logic [31:0] out_rd, out_jump_dest;

    int n_total = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] rd;
        logic        jump;
        logic [31:0] dest;
        logic        ill;
        int          lat;
    } res_t;

    bit   pend = 1'b0;
    int   wait_cnt = 0;
    res_t exp_r;

    always #5 clk = ~clk;

    execute_pipe #(.XLEN(32), .PC_STEP(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_pc        (in_pc),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm       (in_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rd       (out_rd),
        .out_jump_dest(out_jump_dest),
        .out_jump     (out_jump),
        .out_illegal  (out_illegal),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic res_t model_op(input logic [4:0] op, input logic [31:0] pc, a, b, imm);
        res_t r;
        longint sa, sb;
        longint unsigned ua, ub;
        bit muldiv;
`ifdef EXECUTE_MULDIV_EN
        muldiv = 1'b1;
`else
        muldiv = 1'b0;
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r.rd = '0;
        r.jump = 1'b0;
        r.dest = pc + 32'd4;
        r.ill = 1'b0;
        r.lat = 1;
        if (op > 5'd20 || (op >= 5'd16 && !muldiv)) begin
            r.ill = 1'b1;
            return r;
        end
        case (op)
            5'd0:  r.rd = 32'(ua + ub);
            5'd1:  r.rd = 32'(ua - ub);
            5'd2:  r.rd = a & b;
            5'd3:  r.rd = a | b;
            5'd4:  r.rd = a ^ b;
            5'd5:  r.rd = 32'(ua << b[4:0]);
            5'd6:  r.rd = 32'(ua >> b[4:0]);
            5'd7:  r.rd = 32'(sa >>> b[4:0]);
            5'd8:  r.rd = (sa < sb) ? 32'd1 : 32'd0;
            5'd9:  r.rd = (ua < ub) ? 32'd1 : 32'd0;
            5'd10: r.jump = (a == b);
            5'd11: r.jump = (a != b);
            5'd12: r.jump = (sa < sb);
            5'd13: r.jump = (sa >= sb);
            5'd14: begin r.rd = pc + 32'd4; r.jump = 1'b1; r.dest = pc + imm; end
            5'd15: begin r.rd = pc + 32'd4; r.jump = 1'b1; r.dest = (a + imm) & 32'hFFFF_FFFE; end
            5'd16: r.rd = 32'(ua * ub);
            5'd17: begin r.lat = 33; if (b == 0) r.rd = '1; else r.rd = 32'(sa / sb); end
            5'd18: begin r.lat = 33; if (b == 0) r.rd = '1; else r.rd = 32'(ua / ub); end
            5'd19: begin r.lat = 33; if (b == 0) r.rd = a; else r.rd = 32'(sa % sb); end
            5'd20: begin r.lat = 33; if (b == 0) r.rd = a; else r.rd = 32'(ua % ub); end
            default: ;
        endcase
        if (op >= 5'd10 && op <= 5'd13 && r.jump) r.dest = pc + imm;
        return r;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model
    task automatic step(input bit v, input logic [4:0] op, input logic [31:0] pc, a, b, imm,
                        input bit ordy, input bit fl);
        bit exp_valid, exp_busy, exp_rdy;
        @(negedge clk);
        in_valid = v; in_op = op; in_pc = pc; in_rs1 = a; in_rs2 = b; in_imm = imm;
        out_ready = ordy; flush = fl;
        #1;
        exp_valid = pend && (wait_cnt == 0);
        exp_busy  = pend && (wait_cnt > 0);
        exp_rdy   = !fl && (!pend || (exp_valid && ordy));
        check_eq("out_valid", out_valid, exp_valid);
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("busy", busy, exp_busy);
        if (exp_valid) begin
            check_eq("out_rd", out_rd, exp_r.rd);
            check_eq("out_jump", out_jump, exp_r.jump);
            check_eq("out_jump_dest", out_jump_dest, exp_r.dest);
            check_eq("out_illegal", out_illegal, exp_r.ill);
        end
        if (fl) begin
            pend = 1'b0;
        end else begin
            if (exp_valid && ordy) pend = 1'b0;
            if (pend && wait_cnt > 0) wait_cnt--;
            if (v && exp_rdy) begin
                exp_r = model_op(op, pc, a, b, imm);
                pend = 1'b1;
                wait_cnt = exp_r.lat - 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, '0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    // Directed constant check of the result visible just after the next edge
    task automatic expect_next(input string tag, input logic [31:0] rd, input bit jmp,
                               input logic [31:0] dest, input bit ill);
        @(posedge clk);
        #1;
        check_eq({tag, "_valid"}, out_valid, 1'b1);
        check_eq({tag, "_rd"}, out_rd, rd);
        check_eq({tag, "_jump"}, out_jump, jmp);
        check_eq({tag, "_dest"}, out_jump_dest, dest);
        check_eq({tag, "_illegal"}, out_illegal, ill);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rstn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_out_rd", out_rd, 32'd0);
        check_eq("rst_out_jump", out_jump, 1'b0);
        check_eq("rst_out_dest", out_jump_dest, 32'd0);
        check_eq("rst_out_illegal", out_illegal, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);
        pend = 1'b0;
        wait_cnt = 0;
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        do_reset(3);

        step(1'b1, 5'd0, 32'h0, 32'd5, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        expect_next("add", 32'd4, 1'b0, 32'd4, 1'b0);
        step(1'b1, 5'd10, 32'h100, 32'd7, 32'd7, 32'hFFFF_FFF8, 1'b1, 1'b0);
        expect_next("beq", 32'd0, 1'b1, 32'hF8, 1'b0);
        step(1'b1, 5'd11, 32'h100, 32'd7, 32'd7, 32'hFFFF_FFF8, 1'b1, 1'b0);
        expect_next("bne", 32'd0, 1'b0, 32'h104, 1'b0);
        step(1'b1, 5'd15, 32'h40, 32'h1001, 32'd0, 32'd2, 1'b1, 1'b0);
        expect_next("jalr", 32'h44, 1'b1, 32'h1002, 1'b0);
        step(1'b1, 5'd16, 32'h0, 32'd6, 32'd7, 32'd0, 1'b1, 1'b0);
`ifdef EXECUTE_MULDIV_EN
        expect_next("mul", 32'd42, 1'b0, 32'd4, 1'b0);
`else
        expect_next("op16", 32'd0, 1'b0, 32'd4, 1'b1);
`endif

        // Stall for 5 cycles with a new op offered, then a back-to-back stream
        step(1'b1, 5'd0, 32'h0, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 5'd1, '0, 32'd9, 32'd1, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 5'd0, 32'(i * 4), 32'(i), 32'd10, '0, 1'b1, 1'b0);
        idle(2);

        do_reset(1);

`ifdef EXECUTE_MULDIV_EN
        step(1'b1, 5'd17, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        idle(32);
        expect_next("div_ovf", 32'h8000_0000, 1'b0, 32'd4, 1'b0);
        step(1'b1, 5'd18, 32'h0, 32'd123, 32'd0, 32'd0, 1'b1, 1'b0);
        idle(32);
        expect_next("divu_zero", 32'hFFFF_FFFF, 1'b0, 32'd4, 1'b0);

        step(1'b1, 5'd17, 32'h0, 32'd100, 32'd7, 32'd0, 1'b1, 1'b0);
        idle(9);
        step(1'b0, 5'd0, '0, '0, '0, '0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        check_eq("flush_busy", busy, 1'b0);
        check_eq("flush_out_valid", out_valid, 1'b0);
        check_eq("flush_in_ready", in_ready, 1'b1);
        idle(40);

        step(1'b1, 5'd19, 32'h0, 32'd77, 32'd5, 32'd0, 1'b1, 1'b0);
        idle(5);
        do_reset(1);
        idle(40);
`endif

        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                 32'($urandom) & 32'hFFFF_FFFC, rand_val(), rand_val(), rand_val(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end
        idle(40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits (legal values 32 or 64).
REQ-002 Parameter PC_STEP, default 4, link increment added to pc for JAL/JALR.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset; synchronous, active-low.
REQ-005 flush  input  1  kill in-flight and buffered operation.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  block accepts operation this cycle.
REQ-008 in_op  input  5  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 JAL, 15 JALR, 16 MUL, 17 DIV, 18 DIVU, 19 REM, 20 REMU; 21-31 illegal.
REQ-009 in_pc, in_rs1, in_rs2, in_imm  input  XLEN each  pc, operands, sign-extended immediate.
REQ-010 out_valid  output  1  result register holds a result.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 out_rd, out_jump_dest  output  XLEN each  register result, jump target.
REQ-013 out_jump, out_illegal  output  1 each  redirect required, illegal opcode.
REQ-014 busy  output  1  high while in DIV state.

Function
REQ-015 States SHALL be IDLE, DIV, HOLD; transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-016 in_ready SHALL equal (state==IDLE) || (state==HOLD && out_ready), and SHALL be 0 while flush is high.
REQ-017 Non-divide ops SHALL produce the result in the output register one cycle after transfer in (latency 1) and enter HOLD.
REQ-018 In HOLD, transfer out without transfer in SHALL return to IDLE; with a simultaneous transfer in, the new op SHALL be accepted (throughput 1/cycle).
REQ-019 Arithmetic SHALL be modulo 2^XLEN; shift amount = rs2[log2(XLEN)-1:0]; SLT/SLTU write 1 or 0.
REQ-020 Branches: out_rd=0; out_jump=condition; out_jump_dest = pc+imm if taken else pc+PC_STEP.
REQ-021 JAL: out_rd=pc+PC_STEP, out_jump=1, dest=pc+imm; JALR: same rd, dest=(rs1+imm) with bit 0 cleared.
REQ-022 Non-jump ops: out_jump=0, out_jump_dest=pc+PC_STEP.
REQ-023 MUL SHALL return the low XLEN bits of the product with latency 1.
REQ-024 DIV/DIVU/REM/REMU SHALL enter DIV, run a restoring divider for exactly XLEN cycles, then load the result and enter HOLD (latency XLEN+1).
REQ-025 Divide by zero: quotient all ones, remainder = dividend; signed MIN / -1: quotient MIN, remainder 0; both still take XLEN+1 cycles.
REQ-026 Illegal opcode: out_illegal=1, out_rd=0, out_jump=0, latency 1.
REQ-027 Output register contents SHALL stay stable while out_valid && !out_ready.
REQ-028 flush SHALL, at the next edge, clear out_valid, abort any division and force IDLE; flush overrides a same-cycle in_valid and out_ready.

Reset
REQ-029 With rstn low at a clock edge: state=IDLE, out_valid=0, out_rd=0, out_jump=0, out_jump_dest=0, out_illegal=0, busy=0, divider counter=0.
REQ-030 Reset during DIV SHALL discard the division; no result SHALL appear afterwards.
REQ-031 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-032 Macro EXECUTE_MULDIV_EN: when defined, opcodes 16-20 SHALL behave per REQ-023..025.
REQ-033 When EXECUTE_MULDIV_EN is undefined, opcodes 16-20 SHALL be illegal per REQ-026, no divider or multiplier logic SHALL exist, and busy SHALL be tied 0.

Verification
REQ-034 ADD rs1=5, rs2=0xFFFFFFFF, out_ready=1 -> next cycle out_valid=1, out_rd=4, out_jump=0.
REQ-035 BEQ pc=0x100, rs1=rs2=7, imm=-8 -> out_jump=1, dest=0xF8; BNE with the same inputs -> out_jump=0, dest=0x104.
REQ-036 JALR pc=0x40, rs1=0x1001, imm=2 -> out_rd=0x44, dest=0x1002, out_jump=1.
REQ-037 DIV rs1=0x80000000, rs2=0xFFFFFFFF (MULDIV_EN, XLEN=32) -> busy for 32 cycles, out_valid at cycle 33, out_rd=0x80000000; DIVU rs2=0 -> out_rd=0xFFFFFFFF.
REQ-038 out_ready=0 for 5 cycles after ADD result -> out_rd stable, in_ready=0; then a back-to-back stream of 4 ADDs with out_ready=1 -> 4 results in 4 consecutive cycles.
REQ-039 flush in 10th cycle of DIV -> next cycle busy=0, out_valid=0, in_ready=1; opcode 16 without macro -> out_illegal=1.
